// File: rtl/audio_echo_if.sv
// Codec FIFO handshake bundle between the audio controller and the echo stage.
// The echo stage is the master: it issues pop/push strobes and drives output samples.
interface audio_echo_if;
  logic        audio_in_available;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;
  logic        audio_out_allowed;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        write_audio_out;

  modport master (
    input  audio_in_available, left_channel_audio_in, right_channel_audio_in, audio_out_allowed,
    output read_audio_in, left_channel_audio_out, right_channel_audio_out, write_audio_out
  );
  modport slave (
    output audio_in_available, left_channel_audio_in, right_channel_audio_in, audio_out_allowed,
    input  read_audio_in, left_channel_audio_out, right_channel_audio_out, write_audio_out
  );
endinterface

// File: rtl/audio_echo_stage.sv
// Stereo feedback echo: pops a sample, mixes in an attenuated copy from a delay RAM,
// pushes the saturated sum and stores it back so echoes recirculate.
module audio_echo_stage #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] delay_samples,
  input  logic [2:0]        feedback_shift,
  output logic              busy_clearing,
  audio_echo_if.master      bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NCH   = 2;

  typedef enum logic [2:0] {CLEAR, IDLE, READ, MIX, WRITE} state_t;

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             wr_ptr_q, wr_ptr_d, clr_addr_q, clr_addr_d;
  logic                          busy_q, busy_d, rd_q, rd_d, wr_q, wr_d;
  logic [NCH-1:0][31:0]          in_q, in_d, out_q, out_d;

  // Channel 0 = left, channel 1 = right throughout.
  logic [NCH-1:0][DATA_W-1:0]    ram [DEPTH];
  logic [NCH-1:0][DATA_W-1:0]    ram_rd_q, ram_wdata;
  logic [ADDR_W-1:0]             ram_waddr, rd_addr;
  logic                          ram_we, bypass;
  logic [NCH-1:0][31:0]          echo, sat;
  logic [NCH-1:0][32:0]          mix;

  // Natural ADDR_W wrap gives the modulo-DEPTH tap position.
  assign rd_addr = wr_ptr_q - delay_samples;
  assign bypass  = !enable || (delay_samples == '0);

  always_ff @(posedge CLOCK_50) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    ram_rd_q <= ram[rd_addr];
  end

  always_comb begin
    echo = '0;
    mix  = '0;
    sat  = '0;
    for (int c = 0; c < NCH; c++) begin
      echo[c] = $signed({ram_rd_q[c], {(32-DATA_W){1'b0}}}) >>> feedback_shift;
      if (bypass) echo[c] = '0;
      mix[c] = {in_q[c][31], in_q[c]} + {echo[c][31], echo[c]};
      if (mix[c][32] != mix[c][31]) sat[c] = mix[c][32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else                          sat[c] = mix[c][31:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    in_d       = in_q;
    out_d      = out_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = clr_addr_q;
    ram_wdata  = '0;
    case (state_q)
      CLEAR: begin
        ram_we     = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (&clr_addr_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      IDLE: if (bus.audio_in_available && bus.audio_out_allowed) begin
        state_d = READ;
        rd_d    = 1'b1;
      end
      READ: begin
        in_d    = {bus.right_channel_audio_in, bus.left_channel_audio_in};
        state_d = MIX;
      end
      MIX: begin
        out_d   = sat;
        wr_d    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        // Stored value is the output itself, so bypassed samples still prime the line.
        ram_we    = 1'b1;
        ram_waddr = wr_ptr_q;
        ram_wdata = {out_q[1][31 -: DATA_W], out_q[0][31 -: DATA_W]};
        wr_ptr_d  = wr_ptr_q + 1'b1;
        state_d   = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      wr_ptr_q   <= '0;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      in_q       <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      in_q       <= in_d;
      out_q      <= out_d;
    end
  end

  assign busy_clearing               = busy_q;
  assign bus.read_audio_in           = rd_q;
  assign bus.write_audio_out         = wr_q;
  assign bus.left_channel_audio_out  = out_q[0];
  assign bus.right_channel_audio_out = out_q[1];
endmodule

// File: tb/tb_audio_echo_stage.sv
// Directed + randomized bench for audio_echo_stage with a 16-entry delay line.
module tb_audio_echo_stage;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [ADDR_W-1:0] delay = '0;
  logic [2:0]        shift = '0;
  logic              busy;
  int                total = 0;
  int                bad = 0;

  logic [15:0] mL [DEPTH];
  logic [15:0] mR [DEPTH];
  int          wp;

  audio_echo_if bus ();

  audio_echo_stage #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
    .CLOCK_50      (clk),
    .reset         (rst),
    .enable        (enable),
    .delay_samples (delay),
    .feedback_shift(shift),
    .busy_clearing (busy),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: stored 16-bit value scaled to 32 bits, shifted, added with clamping.
  function automatic logic [31:0] mixm(input logic [31:0] x, input logic [15:0] st,
                                       input bit byp, input int sh);
    longint e, s;
    e = byp ? 64'sd0 : ((longint'($signed(st)) * 65536) >>> sh);
    s = longint'($signed(x)) + e;
    if (s > 64'sd2147483647)       s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s[31:0];
  endfunction

  task automatic do_reset(input string tag);
    int errs;
    @(negedge clk);
    rst = 1'b1;
    bus.audio_in_available = 1'b1;
    bus.audio_out_allowed  = 1'b1;
    #1;
    check({tag, "/rst_rd"},   32'(bus.read_audio_in), 32'd0);
    check({tag, "/rst_wr"},   32'(bus.write_audio_out), 32'd0);
    check({tag, "/rst_outL"}, bus.left_channel_audio_out, 32'd0);
    check({tag, "/rst_outR"}, bus.right_channel_audio_out, 32'd0);
    check({tag, "/rst_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    rst  = 1'b0;
    errs = 0;
    for (int i = 1; i < DEPTH; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || bus.read_audio_in !== 1'b0 || bus.write_audio_out !== 1'b0) errs++;
    end
    check({tag, "/clear_phase"}, 32'(errs), 32'd0);
    @(negedge clk);
    check({tag, "/busy_low"}, 32'(busy), 32'd0);
    check({tag, "/no_rd_in_clear"}, 32'(bus.read_audio_in), 32'd0);
    bus.audio_in_available = 1'b0;
    bus.audio_out_allowed  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mL[i] = '0;
      mR[i] = '0;
    end
    wp = 0;
  endtask

  task automatic run_sample(input logic [31:0] l, input logic [31:0] r, input bit en,
                            input int d, input int sh, input string tag,
                            output logic [31:0] obs_l, output logic [31:0] obs_r);
    logic [31:0] el, er;
    int ra, n;
    ra = (wp - d) & (DEPTH - 1);
    el = mixm(l, mL[ra], !en || d == 0, sh);
    er = mixm(r, mR[ra], !en || d == 0, sh);
    enable = en;
    delay  = ADDR_W'(d);
    shift  = 3'(sh);
    bus.left_channel_audio_in  = l;
    bus.right_channel_audio_in = r;
    bus.audio_in_available = 1'b1;
    bus.audio_out_allowed  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.read_audio_in !== 1'b1 && n < 20);
    check({tag, "/rd_lat"}, 32'(n), 32'd1);
    bus.audio_in_available = 1'b0;
    bus.audio_out_allowed  = 1'b0;
    @(negedge clk);
    check({tag, "/rd_pulse"}, 32'(bus.read_audio_in), 32'd0);
    @(negedge clk);
    check({tag, "/wr_lat3"}, 32'(bus.write_audio_out), 32'd1);
    obs_l = bus.left_channel_audio_out;
    obs_r = bus.right_channel_audio_out;
    check({tag, "/L"}, obs_l, el);
    check({tag, "/R"}, obs_r, er);
    @(negedge clk);
    check({tag, "/wr_pulse"}, 32'(bus.write_audio_out), 32'd0);
    mL[wp] = el[31:16];
    mR[wp] = er[31:16];
    wp = (wp + 1) % DEPTH;
  endtask

  initial begin
    logic [31:0] ol, or_;
    int n;
    bus.audio_in_available     = 1'b0;
    bus.audio_out_allowed      = 1'b0;
    bus.left_channel_audio_in  = '0;
    bus.right_channel_audio_in = '0;

    do_reset("init");

    // Dry pass-through
    run_sample(32'h0012_3456, 32'hFFFF_FFFB, 1'b0, 4, 1, "dry", ol, or_);
    check("dry/L_const", ol, 32'h0012_3456);
    check("dry/R_const", or_, 32'hFFFF_FFFB);

    // Impulse with halving feedback
    do_reset("imp_rst");
    for (int i = 0; i < 13; i++) begin
      run_sample(i == 0 ? 32'h4000_0000 : 32'h0, 32'h0, 1'b1, 4, 1, "imp", ol, or_);
      if (i == 4)  check("imp/n4",  ol, 32'h2000_0000);
      if (i == 8)  check("imp/n8",  ol, 32'h1000_0000);
      if (i == 12) check("imp/n12", ol, 32'h0800_0000);
    end

    // Saturation both directions
    do_reset("sat_rst");
    run_sample(32'h7000_0000, 32'h9000_0000, 1'b1, 1, 0, "sat0", ol, or_);
    run_sample(32'h7000_0000, 32'h9000_0000, 1'b1, 1, 0, "sat1", ol, or_);
    check("sat/pos", ol, 32'h7FFF_FFFF);
    check("sat/neg", or_, 32'h8000_0000);

    // Random stream across pointer wrap
    do_reset("wrap_rst");
    for (int i = 0; i < 40; i++)
      run_sample($urandom, $urandom, 1'b1, 3, int'($urandom_range(0, 3)), "wrap", ol, or_);

    // Input available but no output room: no pop
    bus.audio_in_available = 1'b1;
    bus.audio_out_allowed  = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.read_audio_in !== 1'b0) n++;
    end
    check("no_room/rd", 32'(n), 32'd0);
    bus.audio_in_available = 1'b0;

    // Reset while in MIX: push must never happen, RAM re-zeroed
    bus.left_channel_audio_in  = 32'h1234_5678;
    bus.audio_in_available = 1'b1;
    bus.audio_out_allowed  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.read_audio_in !== 1'b1 && n < 20);
    check("mixrst/rd", 32'(bus.read_audio_in), 32'd1);
    bus.audio_in_available = 1'b0;
    do_reset("mixrst");
    run_sample(32'h0101_0101, 32'hF0F0_0000, 1'b1, 5, 0, "post", ol, or_);
    check("post/L_dry", ol, 32'h0101_0101);
    check("post/R_dry", or_, 32'hF0F0_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
